// File: rtl/embcpu4k_mem_copy_master_if.sv
// Avalon-MM bus between the copy master and the on-chip memory slave.
// Ports: master drives address/chipselect/read/write/byteenable/writedata; slave returns readdata/waitrequest.
interface embcpu4k_mem_copy_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_address;
    logic                m_chipselect;
    logic                m_read;
    logic                m_write;
    logic [DATA_W/8-1:0] m_byteenable;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W-1:0]   m_readdata;
    logic                m_waitrequest;

    modport master (
        output m_address,
        output m_chipselect,
        output m_read,
        output m_write,
        output m_byteenable,
        output m_writedata,
        input  m_readdata,
        input  m_waitrequest
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_read,
        input  m_write,
        input  m_byteenable,
        input  m_writedata,
        output m_readdata,
        output m_waitrequest
    );
endinterface

// File: rtl/embcpu4k_mem_copy_master.sv
// Word-by-word memory copy master with running modulo-2^DATA_W checksum.
// Ports: clk, reset (async high); start/src_addr/dst_addr/len command; busy/done/sum status; bus = Avalon-MM master.
module embcpu4k_mem_copy_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    embcpu4k_mem_copy_master_if.master bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ZERO = 0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WRITE,
        FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   cnt;

    // m_writedata doubles as the data buffer: it is loaded in CAPT and
    // held through WRITE, so no separate holding register is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            src              <= '0;
            dst              <= '0;
            cnt              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            sum              <= '0;
            bus.m_address    <= '0;
            bus.m_chipselect <= 1'b0;
            bus.m_read       <= 1'b0;
            bus.m_write      <= 1'b0;
            bus.m_byteenable <= '0;
            bus.m_writedata  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sum <= '0;
                        if (len != CNT_ZERO) begin
                            src              <= src_addr;
                            dst              <= dst_addr;
                            cnt              <= len;
                            busy             <= 1'b1;
                            bus.m_read       <= 1'b1;
                            bus.m_chipselect <= 1'b1;
                            bus.m_address    <= src_addr;
                            state            <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                READ: begin
                    if (!bus.m_waitrequest) begin
                        bus.m_read       <= 1'b0;
                        bus.m_chipselect <= 1'b0;
                        state            <= CAPT;
                    end
                end
                CAPT: begin
                    bus.m_writedata  <= bus.m_readdata;
                    sum              <= sum + bus.m_readdata;
                    bus.m_write      <= 1'b1;
                    bus.m_chipselect <= 1'b1;
                    bus.m_address    <= dst;
                    bus.m_byteenable <= {BE_W{1'b1}};
                    state            <= WRITE;
                end
                WRITE: begin
                    if (!bus.m_waitrequest) begin
                        bus.m_write      <= 1'b0;
                        bus.m_byteenable <= '0;
                        src              <= src + ADDR_ONE;
                        dst              <= dst + ADDR_ONE;
                        cnt              <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            bus.m_chipselect <= 1'b0;
                            busy             <= 1'b0;
                            done             <= 1'b1;
                            state            <= FIN;
                        end else begin
                            // Chipselect stays high straight into the next read.
                            bus.m_read    <= 1'b1;
                            bus.m_address <= src + ADDR_ONE;
                            state         <= READ;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/embcpu4k_mem_copy_master.md
# embcpu4k_mem_copy_master

Avalon-MM master that copies a block of 32-bit words from one word address range to another inside the embcpu4k on-chip memory. It is the initiating end of the same single-port memory slave interface (10-bit word address, 4-bit byteenable, fixed read latency 1). It is used for boot-time relocation and buffer moves without CPU involvement. A local start/busy/done handshake launches it, and it reports a running modular checksum of the copied data.

## Interface
- ADDR_W, 10, word address width; the address space is 2^ADDR_W words.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value.
- start  in  1  command strobe; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address; latched on an accepted start.
- dst_addr  in  ADDR_W  first destination word address; latched on an accepted start.
- len  in  ADDR_W+1  number of words to copy, 0..2^ADDR_W; latched on an accepted start.
- busy  out  1  high while a copy is in progress.
- done  out  1  one-cycle pulse when a copy completes.
- sum  out  DATA_W  modulo-2^DATA_W sum of all words copied by the last or current command.
- m_address  out  ADDR_W  memory word address.
- m_chipselect  out  1  high whenever m_read or m_write is high.
- m_read  out  1  read request.
- m_write  out  1  write request.
- m_byteenable  out  DATA_W/8  all ones whenever m_write is high, otherwise 0.
- m_writedata  out  DATA_W  write data.
- m_readdata  in  DATA_W  read data, valid exactly one cycle after the read is accepted.
- m_waitrequest  in  1  holds the current request; a request is accepted in a cycle where it is high and m_waitrequest is low.

## Operation
- FSM states: IDLE, READ, CAPT, WRITE, FIN.
- IDLE:
  - start=1 with len>0: latch src, dst and count=len; clear sum; go to READ.
  - start=1 with len=0: clear sum; go to FIN with no bus access.
- READ: drive m_read=1, m_chipselect=1, m_address=src. On acceptance go to CAPT. While m_waitrequest=1, hold all outputs unchanged.
- CAPT: all requests low. Register m_readdata into the data buffer, add it to sum, go to WRITE.
- WRITE: drive m_write=1, m_chipselect=1, m_address=dst, m_writedata=buffer, m_byteenable=all ones. On acceptance:
  - src+=1, dst+=1, count-=1.
  - Go to FIN if count becomes 0, else go to READ.
- FIN: done=1 for exactly this cycle; return to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W; 1023+1 gives 0.
- Copy order is strictly ascending, one word at a time, read before write. Overlapping ranges are not special-cased: the result is whatever ascending order produces.
- start while not in IDLE is ignored. Command inputs are not sampled outside IDLE.
- busy is high in READ, CAPT and WRITE; it is low in IDLE and FIN.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - busy, done, m_read, m_write and m_chipselect are 0.
  - m_address, m_writedata, m_byteenable and sum are 0.
  - An in-flight copy is abandoned; memory contents already written remain.

## Timing
- Start is accepted at rising edge T. The first READ cycle is T+1.
- With m_waitrequest=0 throughout, each word takes 3 cycles (READ, CAPT, WRITE). Word k (k=1..N) is written in cycle T+3k.
- done is high in cycle T+3N+1. busy is high in cycles T+1..T+3N.
- With len=0, done is high in cycle T+1 and busy never rises.
- Each cycle of m_waitrequest=1 during READ or WRITE adds exactly one cycle.
- A new start may be accepted in the first IDLE cycle after FIN.
- sum is updated at the end of CAPT and is stable from FIN until the next accepted start.

## Test plan
- Basic copy: memory model holds words 0x11111111..0x44444444 at 0x010..0x013. Start with src=0x010, dst=0x200, len=4. Required: addresses 0x200..0x203 hold the same 4 words; done in cycle T+13; sum=0xAAAAAAAA.
- Zero length: start with len=0. Required: no m_read or m_write ever asserted; done in cycle T+1; sum=0.
- Stalls: hold m_waitrequest=1 for 2 cycles on the first read and 3 cycles on the first write, len=1. Required: m_address and m_writedata stay stable during each stall; done in cycle T+3+5+1=T+9.
- Wrap-around: src=0x3FE, dst=0x0FE, len=4. Required: reads from 0x3FE, 0x3FF, 0x000, 0x001; writes to 0x0FE..0x101.
- Ignored start plus full length: pulse start with other arguments during a copy; the first copy must complete unchanged. Then run len=1024. Required: all 1024 words are copied and done occurs in cycle T+3073.
- Reset mid-copy: assert reset during the WRITE of word 2 of len=4. Required: all outputs are 0 immediately; only word 1 has been written; the next start runs normally.
